trace_memory: RTL and testbench

- Memory-side responder for the TraceLogger buffer interface.
- Holds the DEPTH x WIDTH trace buffer and generates the read/write slot signal RW_TURN.
- Services the logger's pointer-addressed writes and reads, and tracks fill level to drive WRITE_ALLOW/READ_ALLOW back to the logger.
- Sits between the TraceLogger and the physical RAM; it is the counterpart of the logger's memory port.

---
 rtl/trace_memory.sv | 124 ++++++++++++
 tb/tb_trace_memory.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_memory.sv
// Trace buffer RAM responder for the TraceLogger: alternating write/read slots, fill-level tracking, registered read data.
// Optional stored-parity checking is enabled with `define TRACE_MEMORY_PARITY_EN.
module trace_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       CLK_I,
  input  logic                       RST_NI,
  output logic                       RW_TURN_O,
  input  logic                       WRITE_I,
  input  logic [$clog2(DEPTH)-1:0]   WRITE_PTR_I,
  input  logic [WIDTH-1:0]           DMEM_I,
  input  logic                       READ_I,
  input  logic [$clog2(DEPTH)-1:0]   READ_PTR_I,
  output logic [WIDTH-1:0]           DMEM_O,
  input  logic                       OVERWRITE_I,
  input  logic                       CLEAR_I,
  output logic                       WRITE_ALLOW_O,
  output logic                       READ_ALLOW_O,
`ifdef TRACE_MEMORY_PARITY_EN
  output logic                       PARITY_ERR_O,
`endif
  output logic [$clog2(DEPTH):0]     LEVEL_O
);

  localparam int LW = $clog2(DEPTH) + 1;
`ifdef TRACE_MEMORY_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic              rw_turn_q;
  logic              rw_turn_d;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic [WIDTH-1:0]  dmem_q;
  logic [WIDTH-1:0]  dmem_d;
  logic [MW-1:0]     mem_q [DEPTH];
  logic [MW-1:0]     wr_word;
  logic              full;
  logic              wr_acc;
  logic              rd_acc;

  // Slot handshake: a write is taken at an edge where RW_TURN_O=0, WRITE_I=1 and
  // WRITE_ALLOW_O=1; a read where RW_TURN_O=1, READ_I=1 and READ_ALLOW_O=1.
  // Nothing else is acknowledged; refused requests are silently dropped.
  assign full          = (level_q == LW'(DEPTH));
  assign WRITE_ALLOW_O = ~full | OVERWRITE_I;
  assign READ_ALLOW_O  = (level_q != '0);
  assign wr_acc        = RST_NI & ~rw_turn_q & WRITE_I & WRITE_ALLOW_O;
  assign rd_acc        = RST_NI & rw_turn_q & READ_I & READ_ALLOW_O;

  assign RW_TURN_O = rw_turn_q;
  assign DMEM_O    = dmem_q;
  assign LEVEL_O   = level_q;

`ifdef TRACE_MEMORY_PARITY_EN
  assign wr_word = {^DMEM_I, DMEM_I};
`else
  assign wr_word = DMEM_I;
`endif

  always_comb begin
    rw_turn_d = ~rw_turn_q;
    dmem_d    = dmem_q;
    level_d   = level_q;
    if (rd_acc) begin
      dmem_d = mem_q[READ_PTR_I][WIDTH-1:0];
    end
    // Clear wins over any counted access; a full overwrite keeps the level pinned.
    if (CLEAR_I) begin
      level_d = '0;
    end else if (wr_acc && !full) begin
      level_d = level_q + LW'(1);
    end else if (rd_acc) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rw_turn_q <= 1'b0;
      level_q   <= '0;
      dmem_q    <= '0;
    end else begin
      rw_turn_q <= rw_turn_d;
      level_q   <= level_d;
      dmem_q    <= dmem_d;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (wr_acc) begin
      mem_q[WRITE_PTR_I] <= wr_word;
    end
  end

`ifdef TRACE_MEMORY_PARITY_EN
  logic parity_err_q;
  logic parity_err_d;

  // Stored word plus parity bit must XOR to zero; anything else is corruption.
  always_comb begin
    parity_err_d = parity_err_q;
    if (CLEAR_I) begin
      parity_err_d = 1'b0;
    end else if (rd_acc && (^mem_q[READ_PTR_I])) begin
      parity_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign PARITY_ERR_O = parity_err_q;
`endif

endmodule

// File: tb/tb_trace_memory.sv
// Bench for trace_memory (DEPTH=8): directed vector table, hand-written corner sequences and random traffic vs a reference model.
module tb_trace_memory;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int LW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rw_turn, wr, rd, ow, clr, wa, ra;
  logic [AW-1:0] wptr, rptr;
  logic [W-1:0]  din, dout;
  logic [LW-1:0] level;
`ifdef TRACE_MEMORY_PARITY_EN
  logic          perr;
`endif

  trace_memory #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .RW_TURN_O(rw_turn),
    .WRITE_I(wr), .WRITE_PTR_I(wptr), .DMEM_I(din),
    .READ_I(rd), .READ_PTR_I(rptr), .DMEM_O(dout),
    .OVERWRITE_I(ow), .CLEAR_I(clr),
    .WRITE_ALLOW_O(wa), .READ_ALLOW_O(ra),
`ifdef TRACE_MEMORY_PARITY_EN
    .PARITY_ERR_O(perr),
`endif
    .LEVEL_O(level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_turn;
  int          m_level;
  logic [W-1:0] m_dout;
  logic [W-1:0] m_mem [D];
  bit          m_corrupt [D];
  bit          m_perr;
  logic [W-1:0] exp_q[$];

  typedef struct {
    bit            w;
    logic [AW-1:0] wp;
    logic [W-1:0]  d;
    bit            r;
    logic [AW-1:0] rp;
    logic [LW-1:0] exp_level;
    bit            exp_wa;
    bit            exp_ra;
    logic [W-1:0]  exp_dout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("rw_turn", 64'(rw_turn), 64'(m_turn));
    check("level", 64'(level), 64'(m_level));
    check("write_allow", 64'(wa), 64'((m_level < D) || ow));
    check("read_allow", 64'(ra), 64'(m_level != 0));
    check("dmem_o", 64'(dout), 64'(m_dout));
`ifdef TRACE_MEMORY_PARITY_EN
    check("parity_err", 64'(perr), 64'(m_perr));
`endif
  endtask

  task automatic model_reset();
    m_turn  = 1'b0;
    m_level = 0;
    m_dout  = '0;
    m_perr  = 1'b0;
    exp_q.delete();
  endtask

  // One clock: model predicts from the inputs in place before the edge.
  task automatic cycle();
    bit wr_ok, rd_ok;
    wr_ok = !m_turn && wr && ((m_level < D) || ow);
    rd_ok = m_turn && rd && (m_level > 0);
    @(posedge clk); #1;
    if (wr_ok) begin
      m_mem[wptr] = din;
      m_corrupt[wptr] = 1'b0;
    end
    if (rd_ok) begin
      m_dout = m_mem[rptr];
      exp_q.push_back(m_dout);
      if (m_corrupt[rptr]) m_perr = 1'b1;
    end
    if (clr) begin
      m_level = 0;
      m_perr = 1'b0;
    end else if (wr_ok) m_level = (m_level < D) ? m_level + 1 : D;
    else if (rd_ok) m_level = m_level - 1;
    m_turn = !m_turn;
    check_outputs();
    if (exp_q.size() > 0) check("rd_data", 64'(dout), 64'(exp_q.pop_front()));
  endtask

  task automatic drive(input bit w, input logic [AW-1:0] wp, input logic [W-1:0] d,
                       input bit r, input logic [AW-1:0] rp, input bit c);
    wr = w; wptr = wp; din = d; rd = r; rptr = rp; clr = c;
    cycle();
    wr = 0; rd = 0; clr = 0;
  endtask

  task automatic wait_slot(input bit t);
    for (int k = 0; k < 2 && m_turn != t; k++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] p, input logic [W-1:0] d);
    wait_slot(0);
    drive(1, p, d, 0, 0, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] p);
    wait_slot(1);
    drive(0, 0, 0, 1, p, 0);
  endtask

  task automatic do_clear();
    drive(0, 0, 0, 0, 0, 1);
  endtask

  vec_t vecs [8];

  initial begin
    wr = 0; rd = 0; ow = 0; clr = 0; wptr = 0; rptr = 0; din = 0;
    model_reset();
    for (int i = 0; i < D; i++) m_corrupt[i] = 1'b0;

    // reset release, then slot alternation from a write slot
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);

    // fill every address so later random reads never see uninitialised words
    for (int i = 0; i < D; i++) do_write(AW'(i), $urandom);
    do_clear();

    // directed vector table, starting in a write slot with level 0
    vecs[0] = '{1, 3, 32'hDEADBEEF, 0, 0, 1, 1, 1, 32'h0};
    vecs[1] = '{0, 0, 0, 1, 3, 0, 1, 0, 32'hDEADBEEF};
    vecs[2] = '{0, 0, 0, 1, 3, 0, 1, 0, 32'hDEADBEEF};
    vecs[3] = '{1, 5, 32'h99, 0, 0, 0, 1, 0, 32'hDEADBEEF};
    vecs[4] = '{1, 5, 32'h11, 0, 0, 1, 1, 1, 32'hDEADBEEF};
    vecs[5] = '{0, 0, 0, 0, 0, 1, 1, 1, 32'hDEADBEEF};
    vecs[6] = '{1, 6, 32'h22, 0, 0, 2, 1, 1, 32'hDEADBEEF};
    vecs[7] = '{0, 0, 0, 1, 5, 1, 1, 1, 32'h11};
    wait_slot(0);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].w, vecs[i].wp, vecs[i].d, vecs[i].r, vecs[i].rp, 0);
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
      check($sformatf("vec%0d_wa", i), 64'(wa), 64'(vecs[i].exp_wa));
      check($sformatf("vec%0d_ra", i), 64'(ra), 64'(vecs[i].exp_ra));
      check($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
    end

    // fill to DEPTH without overwrite, refused 9th write, drain, refused extra read
    do_clear();
    for (int i = 0; i < D; i++) do_write(AW'(i), 32'hA0 + W'(i));
    check("full_level", 64'(level), 64'(8));
    check("full_wa", 64'(wa), 64'(0));
    do_write(0, 32'hBAD);
    check("ninth_level", 64'(level), 64'(8));
    for (int i = 0; i < D; i++) begin
      do_read(AW'(i));
      if (i == 0) check("ninth_ignored", 64'(dout), 64'(32'hA0));
    end
    check("empty_ra", 64'(ra), 64'(0));
    do_read(3);
    check("empty_read_hold", 64'(dout), 64'(32'hA7));

    // overwrite mode past full
    do_clear();
    ow = 1;
    for (int i = 0; i < 10; i++) do_write(AW'(i % D), W'(i));
    check("ow_level", 64'(level), 64'(8));
    check("ow_wa", 64'(wa), 64'(1));
    ow = 0;
    do_read(0);
    check("ow_mem0", 64'(dout), 64'(8));
    do_read(1);
    check("ow_mem1", 64'(dout), 64'(9));

    // clear together with an accepted write at level 5
    do_clear();
    for (int i = 0; i < 5; i++) do_write(AW'(i), 32'h50 + W'(i));
    wait_slot(0);
    drive(1, 5, 32'h55, 0, 0, 1);
    check("clear_level", 64'(level), 64'(0));
    do_write(6, 32'h66);
    do_read(5);
    check("clear_word_kept", 64'(dout), 64'(32'h55));

    // asynchronous reset mid-stream, checked before any clock edge
    do_write(1, 32'h1234);
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    check("async_turn", 64'(rw_turn), 64'(0));
    check("async_level", 64'(level), 64'(0));
    check("async_dout", 64'(dout), 64'(0));
    check("async_wa", 64'(wa), 64'(1));
    check("async_ra", 64'(ra), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr   = ($urandom_range(0, 2) != 0);
      rd   = ($urandom_range(0, 2) != 0);
      wptr = AW'($urandom_range(0, D - 1));
      rptr = AW'($urandom_range(0, D - 1));
      din  = $urandom;
      clr  = ($urandom_range(0, 30) == 0);
      if (i % 50 == 0) ow = ($urandom_range(0, 1) == 1);
      cycle();
    end
    wr = 0; rd = 0; clr = 0; ow = 0;

`ifdef TRACE_MEMORY_PARITY_EN
    do_clear();
    do_write(2, 32'hCAFE0001);
    dut.mem_q[2][W] = ~dut.mem_q[2][W];
    m_corrupt[2] = 1'b1;
    do_read(2);
    check("parity_set", 64'(perr), 64'(1));
    do_write(3, 32'h3);
    check("parity_sticky", 64'(perr), 64'(1));
    do_clear();
    check("parity_cleared", 64'(perr), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
